// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared fetch-stage constants: state codes, response code, reset PC
package npc_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE   = 2'd0;
    localparam fetch_state_t S_REQ    = 2'd1;
    localparam fetch_state_t S_WAIT_R = 2'd2;
    localparam fetch_state_t S_HOLD   = 2'd3;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// rtl/ifu_perf_cnt.sv - fetch/wait-cycle counters, built only with IFU_PERF_CNT_EN
`ifdef IFU_PERF_CNT_EN
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        wait_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cyc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            wait_cyc  <= 32'd0;
        end else begin
            if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
            if (wait_inc)  wait_cyc  <= wait_cyc + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC owner and single-outstanding AR/R fetch FSM feeding decode
// Optional perf counters via IFU_PERF_CNT_EN.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] ILEN_BYTES = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        fetch_err,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cyc
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  redir_pc;
    logic         redir_pend;
    logic         stale;
    logic         take_redir;
    logic [31:0]  redir_target;

    assign araddr  = pc;
    assign arvalid = (state == S_REQ);
    assign rready  = (state == S_WAIT_R);
    assign m_valid = (state == S_HOLD);

    // A same-cycle redirect always beats the captured one.
    assign take_redir   = redirect_valid | redir_pend;
    assign redir_target = redirect_valid ? redirect_pc : redir_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            redir_pc   <= RESET_PC;
            redir_pend <= 1'b0;
            stale      <= 1'b0;
            instF      <= 32'd0;
            pcF        <= RESET_PC;
            snpcF      <= RESET_PC + ILEN_BYTES;
            fetch_err  <= 1'b0;
        end else begin
            if (redirect_valid && state != S_IDLE) begin
                redir_pend <= 1'b1;
                redir_pc   <= redirect_pc;
            end
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    // araddr stays put; the request completes and is dropped later.
                    if (redirect_valid) stale <= 1'b1;
                    if (arready) state <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (redirect_valid) stale <= 1'b1;
                    if (rvalid) begin
                        if (stale || redirect_valid) begin
                            stale      <= 1'b0;
                            redir_pend <= 1'b0;
                            pc         <= take_redir ? redir_target : pc;
                            state      <= S_REQ;
                        end else begin
                            instF     <= rdata;
                            pcF       <= pc;
                            snpcF     <= pc + ILEN_BYTES;
                            fetch_err <= (rresp != RESP_OKAY);
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Consumed or flushed, either way the next fetch starts now.
                    if (m_ready || redirect_valid) begin
                        redir_pend <= 1'b0;
                        pc         <= take_redir ? redir_target : snpcF;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    ifu_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (m_valid & m_ready),
        .wait_inc  (state == S_REQ || state == S_WAIT_R),
        .fetch_cnt (perf_fetch_cnt),
        .wait_cyc  (perf_wait_cyc)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed plus randomized self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        fetch_err;
    logic        m_valid;
    logic        m_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cyc;
    int          exp_fetches = 0;
    int          exp_waits   = 0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr = 32'h8000_0000;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .instF          (instF),
        .pcF            (pcF),
        .snpcF          (snpcF),
        .fetch_err      (fetch_err),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cyc  (perf_wait_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    // One fetch transaction seen from the bus and decode side.
    // rq/rw: redirect during address/data phase; mode 0 plain accept, 1 accept+redirect, 2 flush.
    task automatic fetch(input int ar_d, input int r_d, input bit rq, input bit rw,
                         input int hold_d, input int mode, input logic [1:0] resp,
                         input logic [31:0] tgt);
        logic [31:0] a;
        logic [31:0] t_req;
        int          n;
        a     = exp_addr;
        t_req = tgt + 32'h40;
        n     = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ar_valid", {31'd0, arvalid}, 32'd1);
        chk("ar_addr", araddr, a);
        for (int k = 0; k < ar_d; k++) begin
            redirect_valid = rq && (k == 0);
            redirect_pc    = t_req;
            tick();
            redirect_valid = 1'b0;
            chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
            chk("ar_hold_addr", araddr, a);
        end
        arready        = 1'b1;
        redirect_valid = rq && (ar_d == 0);
        redirect_pc    = t_req;
        tick();
        arready        = 1'b0;
        redirect_valid = 1'b0;
        chk("ar_done", {31'd0, arvalid}, 32'd0);
        chk("rready", {31'd0, rready}, 32'd1);
        for (int k = 0; k < r_d; k++) begin
            redirect_valid = rw && (k == 0);
            redirect_pc    = tgt;
            tick();
            redirect_valid = 1'b0;
            chk("one_outstanding", {31'd0, arvalid}, 32'd0);
        end
        rvalid         = 1'b1;
        rdata          = mem(a);
        rresp          = resp;
        redirect_valid = rw && (r_d == 0);
        redirect_pc    = tgt;
        tick();
        rvalid         = 1'b0;
        redirect_valid = 1'b0;
`ifdef IFU_PERF_CNT_EN
        exp_waits += ar_d + r_d + 2;
`endif
        if (rq || rw) begin
            chk("drop_mvalid", {31'd0, m_valid}, 32'd0);
            chk("drop_rereq", {31'd0, arvalid}, 32'd1);
            exp_addr = rw ? tgt : t_req;
            return;
        end
        chk("m_valid", {31'd0, m_valid}, 32'd1);
        chk("instF", instF, mem(a));
        chk("pcF", pcF, a);
        chk("snpcF", snpcF, a + 32'd4);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, resp != 2'b00});
        for (int k = 0; k < hold_d; k++) begin
            tick();
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_inst", instF, mem(a));
            chk("hold_pc", pcF, a);
            chk("hold_no_ar", {31'd0, arvalid}, 32'd0);
        end
        m_ready        = (mode != 2);
        redirect_valid = (mode != 0);
        redirect_pc    = tgt;
        tick();
        m_ready        = 1'b0;
        redirect_valid = 1'b0;
        chk("hold_exit", {31'd0, m_valid}, 32'd0);
        exp_addr = (mode == 0) ? a + 32'd4 : tgt;
`ifdef IFU_PERF_CNT_EN
        if (mode != 2) exp_fetches++;
`endif
    endtask

    initial begin
        logic [31:0] r;
        rst            = 1'b1;
        arready        = 1'b0;
        rdata          = 32'd0;
        rresp          = 2'b00;
        rvalid         = 1'b0;
        m_ready        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        tick();
        tick();
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_instF", instF, 32'd0);
        chk("rst_pcF", pcF, 32'h8000_0000);
        chk("rst_snpcF", snpcF, 32'h8000_0004);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_araddr", araddr, 32'h8000_0000);
        rst = 1'b0;
        tick();
        chk("idle_one_cycle", {31'd0, arvalid}, 32'd1);

        fetch(0, 0, 0, 0, 0, 0, 2'b00, 32'd0);
        fetch(0, 0, 0, 0, 5, 0, 2'b00, 32'd0);
        fetch(0, 1, 0, 1, 0, 0, 2'b00, 32'h8000_0100);
        fetch(3, 0, 1, 0, 0, 0, 2'b00, 32'h8000_0200);
        fetch(1, 2, 1, 1, 0, 0, 2'b00, 32'h8000_0300);
        fetch(0, 0, 1, 0, 0, 0, 2'b00, 32'h8000_0400);
        fetch(0, 0, 0, 0, 1, 1, 2'b00, 32'h8000_1000);
        fetch(0, 0, 0, 0, 0, 0, 2'b10, 32'd0);
        fetch(0, 0, 0, 0, 2, 2, 2'b00, 32'hFFFF_FFFC);
        fetch(0, 0, 0, 0, 0, 0, 2'b00, 32'd0);
        chk("wrap_addr", exp_addr, 32'd0);
        for (int i = 0; i < 4; i++) fetch(0, 0, 0, 0, 0, 0, 2'b00, 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            fetch($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 2),
                  2'($urandom_range(0, 3)), r & 32'hFFFF_FFFC);
        end

`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, exp_fetches);
        chk("perf_wait_cyc", perf_wait_cyc, exp_waits);
`endif

        // Reset while a read is outstanding.
        fetch(0, 0, 0, 0, 0, 0, 2'b00, 32'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("mid_in_wait", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_rready", {31'd0, rready}, 32'd0);
        chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mid_rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_araddr", araddr, 32'h8000_0000);
        chk("mid_rst_pcF", pcF, 32'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        chk("mid_rst_perf_f", perf_fetch_cnt, 32'd0);
        chk("mid_rst_perf_w", perf_wait_cyc, 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("mid_rst_restart", {31'd0, arvalid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
